// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider controller.
// Holds:
//   - the FSM state encoding
//   - the default operand width
//   - the result width
//   - the active levels of the ready and busy handshake outputs
package div_ctrl_pkg;

    localparam int DIV_DW = 32;          // operand width (register file / HI / LO word)
    localparam int RES_W  = 2 * DIV_DW;  // {remainder, quotient}

    localparam logic READY_ACTIVE = 1'b1;
    localparam logic BUSY_ACTIVE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem      - current partial remainder (DW)
//   dvd      - dividend bits still to shift in; the low bits collect quotient bits (DW)
//   dvs      - divisor magnitude (DW)
//   rem_next - partial remainder after this iteration
//   dvd_next - shifted dividend with the new quotient bit in bit 0
module div_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] dvd,
    input  logic [DW-1:0] dvs,
    output logic [DW-1:0] rem_next,
    output logic [DW-1:0] dvd_next
);

    // Upper DW+1 bits of {rem, dvd} after the left shift.
    logic [DW:0]   shifted;
    // One extra bit on top so the borrow of the trial subtraction is visible.
    logic [DW+1:0] trial;
    logic          no_borrow;
    // When there is no borrow the difference is below the divisor, so its
    // bit DW is always zero and only the low DW bits are kept.
    logic          unused_trial_top;

    assign shifted          = {rem, dvd[DW-1]};
    assign trial            = {1'b0, shifted} - {2'b00, dvs};
    assign no_borrow        = ~trial[DW+1];
    assign unused_trial_top = trial[DW];

    assign rem_next = no_borrow ? trial[DW-1:0] : shifted[DW-1:0];
    assign dvd_next = {dvd[DW-2:0], no_borrow};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider controller (DIV / DIVU).
// One quotient bit is produced per cycle with a restoring shift-subtract step.
// The result is held in END until the issuing stage drops start_i.
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   start_i       - division request, held until the result is consumed
//   annul_i       - flush: cancels an in-flight division, blocks acceptance in IDLE
//   signed_div_i  - 1 = signed, 0 = unsigned
//   opdata1_i     - dividend, sampled only in the accept cycle
//   opdata2_i     - divisor, sampled only in the accept cycle
//   result_o      - {remainder, quotient}; zero outside END
//   ready_o       - result valid (END)
//   busy_o        - stall request while a division is being accepted or computed
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_div_i,
    input  logic [DW-1:0]     opdata1_i,
    input  logic [DW-1:0]     opdata2_i,
    output logic [2*DW-1:0]   result_o,
    output logic              ready_o,
    output logic              busy_o
);

    localparam int CW = $clog2(DW);

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [DW-1:0]     dvd_reg;     // dividend magnitude, becomes quotient magnitude
    logic [DW-1:0]     dvs_reg;     // divisor magnitude
    logic [DW-1:0]     rem_reg;     // partial remainder
    logic              sign1_reg;   // dividend was negative (signed mode only)
    logic              sign2_reg;   // divisor was negative (signed mode only)
    logic              sdiv_reg;
    logic [2*DW-1:0]   result_reg;
    logic              ready_reg;

    logic              accept;
    logic              op1_neg;
    logic              op2_neg;
    logic [DW-1:0]     op1_mag;
    logic [DW-1:0]     op2_mag;
    logic [DW-1:0]     rem_next;
    logic [DW-1:0]     dvd_next;
    logic              q_neg;
    logic              r_neg;
    logic [DW-1:0]     q_fix;
    logic [DW-1:0]     r_fix;

    assign accept  = start_i & ~annul_i;

    // Operand magnitudes; only signed mode treats the MSB as a sign.
    // -2^(DW-1) negates to itself, which is the correct unsigned magnitude.
    assign op1_neg = signed_div_i & opdata1_i[DW-1];
    assign op2_neg = signed_div_i & opdata2_i[DW-1];
    assign op1_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_mag = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    div_step #(
        .DW (DW)
    ) u_step (
        .rem      (rem_reg),
        .dvd      (dvd_reg),
        .dvs      (dvs_reg),
        .rem_next (rem_next),
        .dvd_next (dvd_next)
    );

    // Sign fix-up applied to the final iteration's outputs as END is entered.
    // The overflow case -2^(DW-1) / -1 wraps naturally: equal signs, quotient
    // magnitude 2^(DW-1), remainder 0.
    assign q_neg = sdiv_reg & (sign1_reg ^ sign2_reg);
    assign r_neg = sdiv_reg & sign1_reg;
    assign q_fix = q_neg ? (~dvd_next + 1'b1) : dvd_next;
    assign r_fix = r_neg ? (~rem_next + 1'b1) : rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            sign1_reg  <= 1'b0;
            sign2_reg  <= 1'b0;
            sdiv_reg   <= 1'b0;
            result_reg <= '0;
            ready_reg  <= ~READY_ACTIVE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sign1_reg <= op1_neg;
                        sign2_reg <= op2_neg;
                        sdiv_reg  <= signed_div_i;
                        dvd_reg   <= op1_mag;
                        dvs_reg   <= op2_mag;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state_reg <= IDLE;
                    end else begin
                        state_reg  <= END;
                        ready_reg  <= READY_ACTIVE;
                        result_reg <= '0;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state_reg <= IDLE;
                    end else begin
                        rem_reg <= rem_next;
                        dvd_reg <= dvd_next;
                        cnt_reg <= cnt_reg + CW'(1);
                        if (cnt_reg == CW'(DW - 1)) begin
                            state_reg  <= END;
                            ready_reg  <= READY_ACTIVE;
                            result_reg <= {r_fix, q_fix};
                        end
                    end
                end
                END: begin
                    // Hold the result until the issuing stage releases start_i.
                    if (!start_i) begin
                        state_reg  <= IDLE;
                        ready_reg  <= ~READY_ACTIVE;
                        result_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;
    // The accept cycle counts as busy so the issuing stage stalls immediately.
    assign busy_o   = ((state_reg == ON) || (state_reg == BYZERO) ||
                       ((state_reg == IDLE) && accept)) ? BUSY_ACTIVE : ~BUSY_ACTIVE;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              annul_i;
    logic              signed_div_i;
    logic [31:0]       opdata1_i;
    logic [31:0]       opdata2_i;
    logic [RES_W-1:0]  result_o;
    logic              ready_o;
    logic              busy_o;

    logic [RES_W-1:0]  exp_q[$];
    int                errors = 0;
    int                checks = 0;

    div_ctrl #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: {remainder, quotient}
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Called just after a falling edge; that cycle is cycle 0 of the request.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        exp_q.push_back(model(a, b, s));
    endtask

    // Counts cycles from acceptance until ready_o; bounded. Scrambles the
    // operand inputs after acceptance, which must not affect the result.
    task automatic wait_ready(output int cyc, output int busy_bad);
        cyc = 0;
        busy_bad = 0;
        #1;
        if (busy_o !== 1'b1) busy_bad++;
        while (cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
            if (ready_o === 1'b1) break;
            if (busy_o !== 1'b1) busy_bad++;
        end
    endtask

    task automatic test_divide(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
        int cyc;
        int bb;
        int exp_lat;
        logic [63:0] exp_r;
        exp_lat = (b == 32'd0) ? 2 : 33;
        issue(a, b, s);
        wait_ready(cyc, bb);
        exp_r = exp_q.pop_front();
        checks++;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, exp_lat);
        end
        checks++;
        if (bb !== 0) begin
            errors++;
            $display("FAIL %s busy: low in %0d cycles before ready, want 0", name, bb);
        end
        checks++;
        if (result_o !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h, want %h", name, result_o, exp_r);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_end: got %b, want 0", name, busy_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL %s release: ready=%b result=%h, want 0 and 0", name, ready_o, result_o);
        end
        $display("txn %s a=%h b=%h signed=%0d lat=%0d result=%h expect=%h", name, a, b, s, cyc, result_o, exp_r);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b result=%h, want all 0", ready_o, busy_o, result_o);
        end
        // annul in IDLE blocks acceptance
        issue(32'd50, 32'd5, 1'b0);
        void'(exp_q.pop_back());
        annul_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL annul_idle busy: got %b, want 0", busy_o);
        end
        repeat (3) @(negedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL annul_idle state: busy=%b ready=%b, want 0 0", busy_o, ready_o);
        end
        $display("txn reset/annul_idle ready=%b busy=%b result=%h", ready_o, busy_o, result_o);
    endtask

    task automatic test_vectors();
        test_divide("u100_7",     32'd100,        32'd7,          1'b0);
        test_divide("s-7_2",      32'hFFFF_FFF9,  32'd2,          1'b1);
        test_divide("uFFFFFFF9_2",32'hFFFF_FFF9,  32'd2,          1'b0);
        test_divide("u_div0",     32'd1234,       32'd0,          1'b0);
        test_divide("s_div0",     32'hFFFF_0000,  32'd0,          1'b1);
        test_divide("s_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1);
        test_divide("s7_-2",      32'd7,          32'hFFFF_FFFE,  1'b1);
        test_divide("u_small",    32'd3,          32'hFFFF_FFFF,  1'b0);
        test_divide("u_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            test_divide("rand", a, b, 1'(i % 3 == 1));
        end
    endtask

    task automatic test_annul();
        int hits;
        issue(32'd999, 32'd4, 1'b0);
        void'(exp_q.pop_back());
        repeat (11) @(negedge clk);
        #1;
        // cycle 11 = iteration 10
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        #1;
        annul_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL annul idle_next: busy=%b, want 0", busy_o);
        end
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (ready_o !== 1'b0) hits++;
        end
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL annul ready: high in %0d cycles, want 0", hits);
        end
        $display("txn annul at iter 10 ready_hits=%0d", hits);
        test_divide("after_annul", 32'd100, 32'd7, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bb;
        int bad;
        logic [63:0] exp_r;
        issue(32'd1000, 32'd3, 1'b0);
        wait_ready(cyc, bb);
        exp_r = exp_q.pop_front();
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL hold latency: got %0d, want 33", cyc);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (ready_o !== 1'b1 || result_o !== exp_r) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold stable: %0d bad cycles, want 0 (last result %h, want %h)", bad, result_o, exp_r);
        end
        start_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL hold drop: ready=%b, want 0", ready_o);
        end
        $display("txn hold a=1000 b=3 result=%h expect=%h", exp_r, model(32'd1000, 32'd3, 1'b0));
        test_divide("back_to_back", 32'hFFFF_FF9C, 32'd7, 1'b1);
    endtask

    task automatic test_reset_mid();
        issue(32'd123456, 32'd789, 1'b0);
        void'(exp_q.pop_back());
        repeat (21) @(negedge clk);
        #1;
        rst = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b busy=%b result=%h, want all 0", ready_o, busy_o, result_o);
        end
        $display("txn reset at iter 20 ready=%b busy=%b result=%h", ready_o, busy_o, result_o);
        test_divide("after_reset", 32'd100, 32'd7, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        #1;
        test_reset();
        test_vectors();
        test_random();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
